local_bus_arbiter: RTL and testbench

- Shares the card's internal local bus (SCSI register/ROM/SID/SPI datapath and address/data transceivers) between two requesters: the Zorro slave path (host accesses decoded to this board) and the SCSI chip's DMA master path.
- Sequences the DMA handover: requests the Zorro bus from the Zorro master arbiter, then issues SBG_n to the SCSI chip.
- Inserts a turnaround gap between owners, limits DMA tenure when a slave access is pending, and aborts stalled DMA grant attempts with a watchdog.

---
 rtl/local_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_local_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/local_bus_arbiter.sv
// Local bus arbiter: shares the card's local bus between the Zorro slave path and SCSI DMA.
// Define LOCAL_ARB_STATS_EN to add the stat_preempt/stat_timeout event counters.
module local_bus_arbiter #(
    parameter int TURN_CYCLES    = 2,
    parameter int DMA_MAX_CYCLES = 64,
    parameter int WDOG_CYCLES    = 255
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       slv_req,
    input  logic       slv_done,
    input  logic       SBR_n,
    input  logic       MASTER_n,
    input  logic       zbus_grant,
    output logic       zbus_req,
    output logic       SBG_n,
    output logic       slv_grant,
    output logic       turnaround,
    output logic       timeout,
`ifdef LOCAL_ARB_STATS_EN
    output logic [7:0] stat_preempt,
    output logic [7:0] stat_timeout,
`endif
    output logic [1:0] owner
);

    typedef enum logic [2:0] {
        IDLE,
        SLV,
        DMA_WAIT,
        DMA_GRANT,
        DMA_OWN,
        DMA_RELEASE,
        TURN
    } state_t;

    localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] DMA_LAST  = 8'(DMA_MAX_CYCLES - 1);
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic       last_dma_lost;
    logic       lost_next;
    logic       wdog_fire;
    logic       preempt_hit;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            last_dma_lost <= 1'b0;
        end else begin
            state         <= next_state;
            cnt           <= cnt_next;
            last_dma_lost <= lost_next;
        end
    end

    // One shared counter: watchdog in WAIT/GRANT, tenure in OWN, gap length in TURN.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        lost_next   = last_dma_lost;
        wdog_fire   = 1'b0;
        preempt_hit = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 8'd0;
                if (slv_req && !SBR_n) begin
                    if (last_dma_lost) begin
                        next_state = DMA_WAIT;
                        lost_next  = 1'b0;
                    end else begin
                        next_state = SLV;
                        lost_next  = 1'b1;
                    end
                end else if (slv_req) begin
                    next_state = SLV;
                end else if (!SBR_n) begin
                    next_state = DMA_WAIT;
                    lost_next  = 1'b0;
                end
            end
            SLV: begin
                cnt_next = 8'd0;
                if (slv_done) next_state = TURN;
            end
            DMA_WAIT: begin
                if (SBR_n) begin
                    next_state = TURN;
                    cnt_next   = 8'd0;
                end else if (zbus_grant) begin
                    next_state = DMA_GRANT;
                    cnt_next   = 8'd0;
                end else if (cnt == WDOG_LAST) begin
                    next_state = TURN;
                    cnt_next   = 8'd0;
                    wdog_fire  = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DMA_GRANT: begin
                if (!MASTER_n) begin
                    next_state = DMA_OWN;
                    cnt_next   = 8'd0;
                end else if (cnt == WDOG_LAST) begin
                    next_state = TURN;
                    cnt_next   = 8'd0;
                    wdog_fire  = 1'b1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DMA_OWN: begin
                if (slv_req && (cnt >= DMA_LAST)) begin
                    next_state  = DMA_RELEASE;
                    cnt_next    = 8'd0;
                    preempt_hit = 1'b1;
                end else if (SBR_n && MASTER_n) begin
                    next_state = TURN;
                    cnt_next   = 8'd0;
                end else if (!zbus_grant) begin
                    next_state = DMA_RELEASE;
                    cnt_next   = 8'd0;
                end else if (cnt != 8'hFF) begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DMA_RELEASE: begin
                // The chip must finish its current cycle, so there is no watchdog here.
                cnt_next = 8'd0;
                if (MASTER_n) next_state = TURN;
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    next_state = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear with the state itself.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            zbus_req   <= 1'b0;
            SBG_n      <= 1'b1;
            slv_grant  <= 1'b0;
            turnaround <= 1'b0;
            timeout    <= 1'b0;
            owner      <= 2'b00;
        end else begin
            zbus_req   <= (next_state == DMA_WAIT) || (next_state == DMA_GRANT) ||
                          (next_state == DMA_OWN) || (next_state == DMA_RELEASE);
            SBG_n      <= !((next_state == DMA_GRANT) || (next_state == DMA_OWN));
            slv_grant  <= (next_state == SLV);
            turnaround <= (next_state == TURN);
            timeout    <= wdog_fire;
            if (next_state == SLV)
                owner <= 2'b01;
            else if ((next_state == DMA_GRANT) || (next_state == DMA_OWN) ||
                     (next_state == DMA_RELEASE))
                owner <= 2'b10;
            else
                owner <= 2'b00;
        end
    end

`ifdef LOCAL_ARB_STATS_EN
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            stat_preempt <= 8'd0;
            stat_timeout <= 8'd0;
        end else begin
            if (preempt_hit && (stat_preempt != 8'hFF)) stat_preempt <= stat_preempt + 8'd1;
            if (wdog_fire && (stat_timeout != 8'hFF)) stat_timeout <= stat_timeout + 8'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = preempt_hit;
`endif

endmodule

// File: tb/tb_local_bus_arbiter.sv
// Directed self-checking bench for local_bus_arbiter at default parameters.
// Outputs are compared as one vector {zbus_req, SBG_n, slv_grant, turnaround, timeout, owner}.
module tb_local_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       slv_req = 1'b0;
    logic       slv_done = 1'b0;
    logic       SBR_n = 1'b1;
    logic       MASTER_n = 1'b1;
    logic       zbus_grant = 1'b0;
    logic       zbus_req, SBG_n, slv_grant, turnaround, timeout;
    logic [1:0] owner;
`ifdef LOCAL_ARB_STATS_EN
    logic [7:0] stat_preempt, stat_timeout;
`endif

    int checks = 0;
    int passed = 0;
    int inv_errors = 0;

    localparam logic [6:0] O_IDLE  = 7'b0_1_0_0_0_00;
    localparam logic [6:0] O_SLV   = 7'b0_1_1_0_0_01;
    localparam logic [6:0] O_WAIT  = 7'b1_1_0_0_0_00;
    localparam logic [6:0] O_OWN   = 7'b1_0_0_0_0_10;
    localparam logic [6:0] O_REL   = 7'b1_1_0_0_0_10;
    localparam logic [6:0] O_TURN  = 7'b0_1_0_1_0_00;
    localparam logic [6:0] O_TOUT  = 7'b0_1_0_1_1_00;

    logic [6:0] outs;
    assign outs = {zbus_req, SBG_n, slv_grant, turnaround, timeout, owner};

    local_bus_arbiter dut (
        .CLK(CLK), .RESET_n(RESET_n), .slv_req(slv_req), .slv_done(slv_done),
        .SBR_n(SBR_n), .MASTER_n(MASTER_n), .zbus_grant(zbus_grant),
        .zbus_req(zbus_req), .SBG_n(SBG_n), .slv_grant(slv_grant),
        .turnaround(turnaround), .timeout(timeout),
`ifdef LOCAL_ARB_STATS_EN
        .stat_preempt(stat_preempt), .stat_timeout(stat_timeout),
`endif
        .owner(owner)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RESET_n && ((slv_grant && owner == 2'b10) || (slv_grant && !SBG_n))) inv_errors++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            slv_req = i[0]; SBR_n = i[0]; zbus_grant = ~i[0]; MASTER_n = i[0];
            step(1);
            checks++; if (outs !== O_IDLE) $display("FAIL reset_hold: got %b want %b", outs, O_IDLE); else passed++;
        end
        slv_req = 0; SBR_n = 1; zbus_grant = 0; MASTER_n = 1;
        @(negedge CLK); RESET_n = 1'b1;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL reset_release: got %b want %b", outs, O_IDLE); else passed++;
`ifdef LOCAL_ARB_STATS_EN
        checks++; if (stat_preempt !== 8'd0 || stat_timeout !== 8'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_preempt, stat_timeout); else passed++;
`endif
    endtask

    task automatic test_slave_only;
        slv_req = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (outs !== O_SLV) $display("FAIL slave_grant cyc%0d: got %b want %b", i, outs, O_SLV); else passed++;
        end
        slv_req = 0; slv_done = 1;
        step(1); slv_done = 0;
        checks++; if (outs !== O_TURN) $display("FAIL slave_turn1: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_TURN) $display("FAIL slave_turn2: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL slave_idle: got %b want %b", outs, O_IDLE); else passed++;
    endtask

    task automatic test_dma_normal;
        SBR_n = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++; if (outs !== O_WAIT) $display("FAIL dma_wait cyc%0d: got %b want %b", i, outs, O_WAIT); else passed++;
        end
        zbus_grant = 1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++; if (outs !== O_OWN) $display("FAIL dma_grant cyc%0d: got %b want %b", i, outs, O_OWN); else passed++;
        end
        MASTER_n = 0;
        step(3);
        checks++; if (outs !== O_OWN) $display("FAIL dma_own: got %b want %b", outs, O_OWN); else passed++;
        SBR_n = 1; MASTER_n = 1;
        step(1); zbus_grant = 0;
        checks++; if (outs !== O_TURN) $display("FAIL dma_turn1: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_TURN) $display("FAIL dma_turn2: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL dma_idle: got %b want %b", outs, O_IDLE); else passed++;
    endtask

    task automatic test_preempt;
        SBR_n = 0; zbus_grant = 1;
        step(2);
        MASTER_n = 0;
        step(1);
        checks++; if (outs !== O_OWN) $display("FAIL preempt_own_entry: got %b want %b", outs, O_OWN); else passed++;
        step(10);
        slv_req = 1;
        for (int t = 10; t < 63; t++) begin
            step(1);
            checks++; if (outs !== O_OWN) $display("FAIL preempt_hold tenure%0d: got %b want %b", t + 1, outs, O_OWN); else passed++;
        end
        step(1);
        checks++; if (outs !== O_REL) $display("FAIL preempt_release: got %b want %b", outs, O_REL); else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (outs !== O_REL) $display("FAIL preempt_master_hold cyc%0d: got %b want %b", i, outs, O_REL); else passed++;
        end
        MASTER_n = 1; SBR_n = 1; zbus_grant = 0;
        step(2);
        checks++; if (outs !== O_TURN) $display("FAIL preempt_turn: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL preempt_idle: got %b want %b", outs, O_IDLE); else passed++;
        step(1);
        checks++; if (outs !== O_SLV) $display("FAIL preempt_slave: got %b want %b", outs, O_SLV); else passed++;
`ifdef LOCAL_ARB_STATS_EN
        checks++; if (stat_preempt !== 8'd1) $display("FAIL stat_preempt: got %0d want 1", stat_preempt); else passed++;
`endif
        slv_req = 0; slv_done = 1;
        step(1); slv_done = 0;
        step(2);
        checks++; if (outs !== O_IDLE) $display("FAIL preempt_cleanup: got %b want %b", outs, O_IDLE); else passed++;
    endtask

    task automatic test_watchdog;
        SBR_n = 0;
        for (int i = 0; i < 255; i++) begin
            step(1);
            checks++; if (outs !== O_WAIT) $display("FAIL wdog_wait cyc%0d: got %b want %b", i, outs, O_WAIT); else passed++;
        end
        step(1); SBR_n = 1;
        checks++; if (outs !== O_TOUT) $display("FAIL wdog_abort: got %b want %b", outs, O_TOUT); else passed++;
        step(1);
        checks++; if (outs !== O_TURN) $display("FAIL wdog_single_pulse: got %b want %b", outs, O_TURN); else passed++;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL wdog_idle: got %b want %b", outs, O_IDLE); else passed++;
`ifdef LOCAL_ARB_STATS_EN
        checks++; if (stat_timeout !== 8'd1) $display("FAIL stat_timeout: got %0d want 1", stat_timeout); else passed++;
`endif
    endtask

    task automatic test_grant_beats_watchdog;
        SBR_n = 0;
        step(255);
        zbus_grant = 1;
        step(1);
        checks++; if (outs !== O_OWN) $display("FAIL grant_vs_wdog: got %b want %b", outs, O_OWN); else passed++;
        MASTER_n = 0;
        step(1);
        checks++; if (outs !== O_OWN) $display("FAIL grant_vs_wdog_own: got %b want %b", outs, O_OWN); else passed++;
        SBR_n = 1; MASTER_n = 1;
        step(1); zbus_grant = 0;
        step(2);
        checks++; if (outs !== O_IDLE) $display("FAIL grant_vs_wdog_idle: got %b want %b", outs, O_IDLE); else passed++;
    endtask

    task automatic test_fairness;
        slv_req = 1; SBR_n = 0;
        step(1);
        checks++; if (outs !== O_SLV) $display("FAIL fair_first_slave: got %b want %b", outs, O_SLV); else passed++;
        slv_done = 1;
        step(1); slv_done = 0;
        checks++; if (outs !== O_TURN) $display("FAIL fair_done_wins: got %b want %b", outs, O_TURN); else passed++;
        step(2);
        checks++; if (outs !== O_IDLE) $display("FAIL fair_idle: got %b want %b", outs, O_IDLE); else passed++;
        step(1);
        checks++; if (outs !== O_WAIT) $display("FAIL fair_second_dma: got %b want %b", outs, O_WAIT); else passed++;
        SBR_n = 1;
        step(1);
        checks++; if (outs !== O_TURN) $display("FAIL fair_withdraw: got %b want %b", outs, O_TURN); else passed++;
        step(2);
        step(1);
        checks++; if (outs !== O_SLV) $display("FAIL fair_third_slave: got %b want %b", outs, O_SLV); else passed++;
        slv_req = 0; slv_done = 1;
        step(1); slv_done = 0;
        step(2);
    endtask

    task automatic test_reset_mid;
        SBR_n = 0; zbus_grant = 1;
        step(2);
        MASTER_n = 0;
        step(2);
        checks++; if (outs !== O_OWN) $display("FAIL midreset_own: got %b want %b", outs, O_OWN); else passed++;
        #2 RESET_n = 1'b0;
        #1;
        checks++; if (outs !== O_IDLE) $display("FAIL midreset_async: got %b want %b", outs, O_IDLE); else passed++;
`ifdef LOCAL_ARB_STATS_EN
        checks++; if (stat_preempt !== 8'd0 || stat_timeout !== 8'd0) $display("FAIL midreset_stats: got %0d/%0d want 0/0", stat_preempt, stat_timeout); else passed++;
`endif
        SBR_n = 1; zbus_grant = 0; MASTER_n = 1;
        @(negedge CLK); RESET_n = 1'b1;
        step(1);
        checks++; if (outs !== O_IDLE) $display("FAIL midreset_after: got %b want %b", outs, O_IDLE); else passed++;
    endtask

    initial begin
        test_reset();
        test_slave_only();
        test_dma_normal();
        test_preempt();
        test_watchdog();
        test_grant_beats_watchdog();
        test_fairness();
        test_reset_mid();
        checks++; if (inv_errors !== 0) $display("FAIL invariant: got %0d violations want 0", inv_errors); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
